jtag_mailbox_ctrl: RTL and testbench

JTAG_MAILBOX_CTRL -- requirements
Module: jtag_mailbox_ctrl

---
 rtl/jtag_mailbox_ctrl_if.sv | 24 ++
 rtl/jtag_mailbox_ctrl.sv | 117 +++++++++++
 tb/tb_jtag_mailbox_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_mailbox_ctrl_if.sv
// Bus bundle for jtag_mailbox_ctrl: JTAG receive path, Rx handshake,
// two-requester Tx arbitration and the value returned to JTAG capture.
interface jtag_mailbox_ctrl_if;
    logic [7:0]  jtag_reg_i;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        rx_ready_i;
    logic        rx_overrun_o;
    logic        rx_overrun_clr_i;
    logic [1:0]  req_i;
    logic [15:0] data_i;
    logic [1:0]  gnt_o;
    logic [7:0]  soc_jtag_reg_o;

    modport slave (
        input  jtag_reg_i, rx_ready_i, rx_overrun_clr_i, req_i, data_i,
        output rx_data_o, rx_valid_o, rx_overrun_o, gnt_o, soc_jtag_reg_o
    );

    modport master (
        output jtag_reg_i, rx_ready_i, rx_overrun_clr_i, req_i, data_i,
        input  rx_data_o, rx_valid_o, rx_overrun_o, gnt_o, soc_jtag_reg_o
    );
endinterface

// File: rtl/jtag_mailbox_ctrl.sv
// JTAG mailbox controller: synchronizes and debounces the TCK-domain
// configuration register into a valid/ready Rx mailbox with sticky overrun,
// and round-robin arbitrates two writers onto the JTAG capture register.
module jtag_mailbox_ctrl #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter logic [7:0]  RESET_VAL     = 8'h00
) (
    input logic                 clk_i,
    input logic                 rst_i,
    jtag_mailbox_ctrl_if.slave  bus
);

    localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES - 1);

    logic [7:0] sync1_q, sync2_q;
    logic [7:0] cand_q;
    logic [3:0] cnt_q;
    logic [7:0] stable_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       rx_ovr_q;
    logic [7:0] soc_q;
    logic       last_q;
    logic       accept;
    logic [1:0] gnt_d;

    // Two-flop synchronizer for the asynchronous JTAG register bus
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.jtag_reg_i;
            sync2_q <= sync1_q;
        end
    end

    // Stability filter: restart the count whenever the synchronized value moves
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cand_q <= '0;
            cnt_q  <= '0;
        end else if (sync2_q != cand_q) begin
            cand_q <= sync2_q;
            cnt_q  <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q  <= cnt_q + 4'd1;
        end
    end

    assign accept = (cnt_q == CNT_MAX) && (cand_q != stable_q);

    // Last accepted value, used to suppress repeat events for the same value
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stable_q <= '0;
        end else if (accept) begin
            stable_q <= cand_q;
        end
    end

    // Rx mailbox: newest value wins; overwriting an unconsumed value flags overrun
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            if (accept) begin
                rx_data_q  <= cand_q;
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && bus.rx_ready_i) begin
                rx_valid_q <= 1'b0;
            end

            if (accept && rx_valid_q && !bus.rx_ready_i) begin
                rx_ovr_q <= 1'b1;
            end else if (bus.rx_overrun_clr_i) begin
                rx_ovr_q <= 1'b0;
            end
        end
    end

    // Round-robin grant: on contention favour the requester not granted last
    always_comb begin
        gnt_d = '0;
        if (!rst_i) begin
            case (bus.req_i)
                2'b01:   gnt_d = 2'b01;
                2'b10:   gnt_d = 2'b10;
                2'b11:   gnt_d = last_q ? 2'b01 : 2'b10;
                default: gnt_d = '0;
            endcase
        end
    end

    // Tx capture register and round-robin pointer update on grant
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            soc_q  <= RESET_VAL;
            last_q <= 1'b1;
        end else if (gnt_d[0]) begin
            soc_q  <= bus.data_i[7:0];
            last_q <= 1'b0;
        end else if (gnt_d[1]) begin
            soc_q  <= bus.data_i[15:8];
            last_q <= 1'b1;
        end
    end

    assign bus.rx_data_o      = rx_data_q;
    assign bus.rx_valid_o     = rx_valid_q;
    assign bus.rx_overrun_o   = rx_ovr_q;
    assign bus.gnt_o          = gnt_d;
    assign bus.soc_jtag_reg_o = soc_q;

endmodule

// File: tb/tb_jtag_mailbox_ctrl.sv
// Self-checking bench for jtag_mailbox_ctrl: directed scenarios followed by
// randomized traffic, all checked against a sample-window reference model.
module tb_jtag_mailbox_ctrl;

    localparam int unsigned STABLE = 4;
    localparam logic [7:0]  RSTV   = 8'h5A;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    jtag_mailbox_ctrl_if ifc ();

    jtag_mailbox_ctrl #(.STABLE_CYCLES(STABLE), .RESET_VAL(RSTV)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    // Reference model: a value is accepted once STABLE consecutive
    // post-synchronizer samples agree and differ from the last accepted value.
    logic [7:0] m_pipe [2];
    logic [7:0] m_win  [STABLE];
    logic [7:0] m_stable, m_data, m_soc;
    logic       m_valid, m_ovr, m_last;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_gnt();
        logic [1:0] g;
        g = 2'b00;
        if (!rst) begin
            if (ifc.req_i == 2'b01)      g = 2'b01;
            else if (ifc.req_i == 2'b10) g = 2'b10;
            else if (ifc.req_i == 2'b11) g = (m_last == 1'b1) ? 2'b01 : 2'b10;
        end
        return g;
    endfunction

    task automatic model_reset();
        m_pipe[0] = '0;
        m_pipe[1] = '0;
        for (int i = 0; i < int'(STABLE); i++) m_win[i] = '0;
        m_stable = '0;
        m_data   = '0;
        m_soc    = RSTV;
        m_valid  = 1'b0;
        m_ovr    = 1'b0;
        m_last   = 1'b1;
    endtask

    task automatic model_edge();
        logic       ev, same, ovr_set;
        logic [1:0] g;
        same = 1'b1;
        for (int i = 1; i < int'(STABLE); i++)
            if (m_win[i] != m_win[0]) same = 1'b0;
        ev      = same && (m_win[0] != m_stable);
        ovr_set = ev && m_valid && !ifc.rx_ready_i;
        g       = model_gnt();
        if (ev) begin
            m_data   = m_win[0];
            m_valid  = 1'b1;
            m_stable = m_win[0];
        end else if (m_valid && ifc.rx_ready_i) begin
            m_valid = 1'b0;
        end
        if (ovr_set)                   m_ovr = 1'b1;
        else if (ifc.rx_overrun_clr_i) m_ovr = 1'b0;
        if (g == 2'b01) begin
            m_soc  = ifc.data_i[7:0];
            m_last = 1'b0;
        end else if (g == 2'b10) begin
            m_soc  = ifc.data_i[15:8];
            m_last = 1'b1;
        end
        for (int i = 0; i < int'(STABLE) - 1; i++) m_win[i] = m_win[i+1];
        m_win[STABLE-1] = m_pipe[1];
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = ifc.jtag_reg_i;
    endtask

    // One clock: check the combinational grant, advance the model, check state
    task automatic tick();
        #1;
        chk("gnt", {14'b0, ifc.gnt_o}, {14'b0, model_gnt()});
        model_edge();
        @(posedge clk);
        #1;
        chk("rx_data",    {8'b0, ifc.rx_data_o},      {8'b0, m_data});
        chk("rx_valid",   {15'b0, ifc.rx_valid_o},    {15'b0, m_valid});
        chk("rx_overrun", {15'b0, ifc.rx_overrun_o},  {15'b0, m_ovr});
        chk("soc_reg",    {8'b0, ifc.soc_jtag_reg_o}, {8'b0, m_soc});
    endtask

    // Asynchronous reset asserted between edges; outputs must change at once
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_rx_data",  {8'b0, ifc.rx_data_o},      16'h0000);
        chk("rst_rx_valid", {15'b0, ifc.rx_valid_o},    16'h0000);
        chk("rst_overrun",  {15'b0, ifc.rx_overrun_o},  16'h0000);
        chk("rst_soc",      {8'b0, ifc.soc_jtag_reg_o}, {8'b0, RSTV});
        chk("rst_gnt",      {14'b0, ifc.gnt_o},         16'h0000);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt_held", {14'b0, ifc.gnt_o},         16'h0000);
        chk("rst_soc_held", {8'b0, ifc.soc_jtag_reg_o}, {8'b0, RSTV});
        ifc.req_i = 2'b00;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] vals [5];
        int hold;
        vals[0] = 8'hA5; vals[1] = 8'h3C; vals[2] = 8'h11; vals[3] = 8'h00; vals[4] = 8'hFF;

        ifc.jtag_reg_i       = 8'h00;
        ifc.rx_ready_i       = 1'b0;
        ifc.rx_overrun_clr_i = 1'b0;
        ifc.req_i            = 2'b11;
        ifc.data_i           = 16'h1234;
        do_reset();
        ifc.data_i = 16'h0000;

        // 00 -> A5 held, never consumed: valid by edge STABLE+3, not yet at STABLE+1
        ifc.jtag_reg_i = 8'hA5;
        for (int e = 0; e <= int'(STABLE) + 3; e++) begin
            tick();
            if (e == int'(STABLE) + 1)
                chk("latency_early", {15'b0, ifc.rx_valid_o}, 16'h0000);
        end
        chk("a5_valid",   {15'b0, ifc.rx_valid_o},   16'h0001);
        chk("a5_data",    {8'b0, ifc.rx_data_o},     16'h00A5);
        chk("a5_overrun", {15'b0, ifc.rx_overrun_o}, 16'h0000);

        // Two-cycle glitch to 3C must not produce an event
        ifc.jtag_reg_i = 8'h3C;
        repeat (2) tick();
        ifc.jtag_reg_i = 8'hA5;
        repeat (10) tick();
        chk("glitch_valid",   {15'b0, ifc.rx_valid_o},   16'h0001);
        chk("glitch_data",    {8'b0, ifc.rx_data_o},     16'h00A5);
        chk("glitch_overrun", {15'b0, ifc.rx_overrun_o}, 16'h0000);

        // New value over an unconsumed one: newest wins, overrun set, then cleared
        ifc.jtag_reg_i = 8'h11;
        repeat (10) tick();
        chk("ovr_data", {8'b0, ifc.rx_data_o},     16'h0011);
        chk("ovr_set",  {15'b0, ifc.rx_overrun_o}, 16'h0001);
        ifc.rx_overrun_clr_i = 1'b1;
        tick();
        ifc.rx_overrun_clr_i = 1'b0;
        chk("ovr_clr", {15'b0, ifc.rx_overrun_o}, 16'h0000);
        ifc.rx_ready_i = 1'b1;
        tick();
        ifc.rx_ready_i = 1'b0;
        chk("consume_valid", {15'b0, ifc.rx_valid_o}, 16'h0000);
        chk("consume_data",  {8'b0, ifc.rx_data_o},   16'h0011);

        // Held contention alternates starting with requester 0
        ifc.req_i  = 2'b11;
        ifc.data_i = 16'hBBAA;
        #1;
        chk("rr_gnt0", {14'b0, ifc.gnt_o}, 16'h0001);
        tick();
        chk("rr_soc0", {8'b0, ifc.soc_jtag_reg_o}, 16'h00AA);
        #1;
        chk("rr_gnt1", {14'b0, ifc.gnt_o}, 16'h0002);
        tick();
        chk("rr_soc1", {8'b0, ifc.soc_jtag_reg_o}, 16'h00BB);
        #1;
        chk("rr_gnt2", {14'b0, ifc.gnt_o}, 16'h0001);
        tick();
        chk("rr_soc2", {8'b0, ifc.soc_jtag_reg_o}, 16'h00AA);
        ifc.req_i = 2'b00;

        // Reset mid-filter and during an active grant; no spurious event after
        ifc.jtag_reg_i = 8'h77;
        ifc.req_i      = 2'b01;
        ifc.data_i     = 16'h00CD;
        repeat (5) tick();
        ifc.jtag_reg_i = 8'h00;
        do_reset();
        repeat (10) tick();
        chk("post_rst_valid", {15'b0, ifc.rx_valid_o}, 16'h0000);

        // Randomized traffic against the model, with one reset partway through
        hold = 0;
        for (int i = 0; i < 400; i++) begin
            if (hold == 0) begin
                ifc.jtag_reg_i = vals[$urandom_range(0, 4)];
                if ($urandom_range(0, 3) == 0) ifc.jtag_reg_i = 8'($urandom);
                hold = int'($urandom_range(1, 7));
            end
            hold--;
            ifc.rx_ready_i       = ($urandom_range(0, 2) == 0);
            ifc.rx_overrun_clr_i = ($urandom_range(0, 7) == 0);
            ifc.req_i            = 2'($urandom);
            ifc.data_i           = 16'($urandom);
            if (i == 200) do_reset();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
